// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched pending sources, mask, global enable, lowest-index priority, fixed-length CPU pulse.
// Register port answers one cycle after the request; pulses launch only while the CPU is not stalled on memory.
module irq_ctrl #(
    parameter int NUM_SRC   = 8,
    parameter int PULSE_LEN = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cpu_wait_for_mem,
    output logic               interrupt,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_ack
);

    localparam int CW  = $clog2(PULSE_LEN + 1);
    localparam int PAD = 32 - NUM_SRC;

    localparam logic [1:0] A_PENDING = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_CAUSE   = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_SVC   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [4:0]          r_cause;
    logic [NUM_SRC-1:0]  r_prev;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_mask;
    logic                r_enable;
    logic                r_interrupt;
    logic                r_ack;
    logic [31:0]         r_rdata;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [4:0]          w_cause_nxt;
    logic [NUM_SRC-1:0]  w_rise;
    logic [NUM_SRC-1:0]  w_active;
    logic                w_any;
    logic [4:0]          w_low_idx;
    logic [31:0]         w_pend32;
    logic [31:0]         w_mask32;
    logic [31:0]         w_cause_reg;
    logic [31:0]         w_rd_dat;
    logic                w_wr;
    logic [NUM_SRC-1:0]  w_wr_bits;
    logic [NUM_SRC-1:0]  w_clr;
    logic                w_unused;

    assign w_rise    = irq_src & ~r_prev;
    assign w_active  = r_pending & r_mask;
    assign w_any     = |w_active;
    assign w_pend32  = {{PAD{1'b0}}, r_pending};
    assign w_mask32  = {{PAD{1'b0}}, r_mask};
    assign w_wr      = reg_req & reg_we;
    assign w_wr_bits = reg_wdata[NUM_SRC-1:0];
    assign w_clr     = (w_wr && (reg_addr == A_PENDING)) ? w_wr_bits : '0;
    assign w_unused  = &{1'b0, reg_wdata[31:NUM_SRC]};

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    assign w_cause_reg = {w_any, 26'd0, w_low_idx};

    always_comb begin
        w_rd_dat = '0;
        case (reg_addr)
            A_PENDING: w_rd_dat = w_pend32;
            A_MASK:    w_rd_dat = w_mask32;
            A_CAUSE:   w_rd_dat = w_cause_reg;
            A_CTRL:    w_rd_dat = {31'd0, r_enable};
            default:   w_rd_dat = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && w_any && !cpu_wait_for_mem) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = CW'(PULSE_LEN);
                    w_cause_nxt = w_low_idx;
                end
            end
            ST_PULSE: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_SVC;
                end
            end
            ST_SVC: begin
                // Leave once the latched source is acknowledged, masked off, or globally disabled.
                if (!w_pend32[r_cause] || !w_mask32[r_cause] || !r_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cause     <= '0;
            r_prev      <= '0;
            r_pending   <= '0;
            r_mask      <= '0;
            r_enable    <= 1'b0;
            r_interrupt <= 1'b0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_prev    <= irq_src;
            // A fresh rise wins over a same-cycle clear of that bit.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_wr && (reg_addr == A_MASK)) begin
                r_mask <= w_wr_bits;
            end
            if (w_wr && (reg_addr == A_CTRL)) begin
                r_enable <= reg_wdata[0];
            end
            r_ack       <= reg_req;
            r_rdata     <= (reg_req && !reg_we) ? w_rd_dat : '0;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cause     <= w_cause_nxt;
            r_interrupt <= (w_state_nxt == ST_PULSE);
        end
    end

    assign interrupt = r_interrupt;
    assign reg_ack   = r_ack;
    assign reg_rdata = r_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios then random traffic, every cycle compared against a
// cycle-level reference model of pending/mask/enable and pulse timing.
module tb_irq_ctrl;

    localparam int NS = 8;
    localparam int PL = 3;
    localparam logic [31:0] ALL = (32'd1 << NS) - 32'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] src = '0;
    logic          wait_m = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic          interrupt;
    logic [31:0]   rdata;
    logic          ack;

    int n_pass = 0;
    int n_chk  = 0;
    int n_pulse = 0;
    logic last_int = 1'b0;

    // Reference model state
    logic [31:0] m_prev = '0, m_pend = '0, m_mask = '0;
    logic        m_en = 1'b0;
    int          m_left = 0;
    bit          m_svc = 1'b0;
    int          m_cause = 0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    irq_ctrl #(.NUM_SRC(NS), .PULSE_LEN(PL)) dut (
        .clk              (clk),
        .rst              (rst),
        .irq_src          (src),
        .cpu_wait_for_mem (wait_m),
        .interrupt        (interrupt),
        .reg_req          (req),
        .reg_we           (we),
        .reg_addr         (addr),
        .reg_wdata        (wdata),
        .reg_rdata        (rdata),
        .reg_ack          (ack)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] cause_val(input logic [31:0] p, input logic [31:0] m);
        logic [31:0] a;
        a = p & m;
        return (a != 0) ? (32'h8000_0000 | 32'(lowest(a))) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step();
        logic [31:0] rise, act, clr, rv;
        if (rst) begin
            m_prev = 0; m_pend = 0; m_mask = 0; m_en = 0;
            m_left = 0; m_svc = 0; m_cause = 0; m_ack = 0; m_rdata = 0;
        end else begin
            rise = 32'(src) & ~m_prev;
            act  = m_pend & m_mask;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_svc = 1'b1;
            end else if (m_svc) begin
                if (!m_pend[m_cause] || !m_mask[m_cause] || !m_en) m_svc = 1'b0;
            end else if (m_en && act != 0 && !wait_m) begin
                m_cause = lowest(act);
                m_left  = PL;
            end
            case (addr)
                2'd0: rv = m_pend;
                2'd1: rv = m_mask;
                2'd2: rv = cause_val(m_pend, m_mask);
                default: rv = {31'd0, m_en};
            endcase
            m_ack   = req;
            m_rdata = (req && !we) ? rv : 32'd0;
            clr = 0;
            if (req && we) begin
                if (addr == 2'd0) clr = wdata & ALL;
                if (addr == 2'd1) m_mask = wdata & ALL;
                if (addr == 2'd3) m_en = wdata[0];
            end
            m_pend = (m_pend & ~clr) | rise;
            m_prev = 32'(src);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("int", {31'd0, interrupt}, {31'd0, (m_left > 0)});
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("rdata", rdata, m_rdata);
        if (interrupt && !last_int) n_pulse++;
        last_int = interrupt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        cyc();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        cyc();
        d = rdata;
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int base;

        // Reset and quiet run
        idle(2);
        rst = 1'b0;
        chk("rst_int", {31'd0, interrupt}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        wr(2'd1, 32'hFF);
        wr(2'd3, 32'd1);
        base = n_pulse;
        idle(50);
        chk("quiet_pulses", 32'(n_pulse - base), 32'd0);
        rd(2'd2, d);
        chk("quiet_cause", d, 32'h0);

        // Single source, pulse shape and W1C
        src = 8'h08;
        cyc();
        cyc(); chk("t2_p1", {31'd0, interrupt}, 32'd1);
        cyc(); chk("t2_p2", {31'd0, interrupt}, 32'd1);
        cyc(); chk("t2_p3", {31'd0, interrupt}, 32'd1);
        cyc(); chk("t2_end", {31'd0, interrupt}, 32'd0);
        rd(2'd0, d); chk("t2_pend", d, 32'h08);
        rd(2'd2, d); chk("t2_cause", d, 32'h8000_0003);
        src = '0;
        wr(2'd0, 32'h08);
        idle(10);
        chk("t2_one_pulse", 32'(n_pulse - base), 32'd1);

        // Simultaneous rises: lowest index first
        base = n_pulse;
        src = 8'h24;
        cyc();
        rd(2'd2, d); chk("t3_cause_a", d, 32'h8000_0002);
        src = '0;
        idle(6);
        chk("t3_first", 32'(n_pulse - base), 32'd1);
        wr(2'd0, 32'h04);
        idle(2);
        rd(2'd2, d); chk("t3_cause_b", d, 32'h8000_0005);
        idle(5);
        chk("t3_second", 32'(n_pulse - base), 32'd2);
        wr(2'd0, 32'h20);
        idle(4);

        // Memory stall holds off the launch
        base = n_pulse;
        wait_m = 1'b1;
        src = 8'h01;
        idle(10);
        chk("t4_held", 32'(n_pulse - base), 32'd0);
        wait_m = 1'b0;
        cyc(); chk("t4_rise", {31'd0, interrupt}, 32'd1);
        idle(5);
        src = '0;
        wr(2'd0, 32'h01);
        idle(3);

        // Set beats same-cycle clear
        src = 8'h02; cyc();
        src = '0; cyc();
        idle(5);
        src = 8'h02;
        wr(2'd0, 32'h02);
        rd(2'd0, d); chk("t5_set_wins", d, 32'h02);
        src = '0;
        wr(2'd0, 32'h02);
        idle(4);

        // Reset mid-pulse
        src = 8'h10;
        cyc(); cyc(); cyc();
        chk("t6_in_pulse", {31'd0, interrupt}, 32'd1);
        rst = 1'b1;
        cyc(); chk("t6_rst_int", {31'd0, interrupt}, 32'd0);
        rst = 1'b0;
        rd(2'd0, d); chk("t6_pend", d, 32'd0);
        rd(2'd1, d); chk("t6_mask", d, 32'd0);
        rd(2'd3, d); chk("t6_ctrl", d, 32'd0);
        base = n_pulse;
        idle(5);
        chk("t6_no_event", 32'(n_pulse - base), 32'd0);
        src = '0;
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        wr(2'd3, 32'd1);
        idle(5);
        chk("t6_still_quiet", 32'(n_pulse - base), 32'd0);
        src = 8'h10;
        idle(3);
        chk("t6_new_rise", 32'(n_pulse - base), 32'd1);
        idle(5);
        src = '0;
        wr(2'd0, 32'h10);
        idle(3);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
            end
            wait_m = ($urandom_range(0, 3) == 0);
            req    = ($urandom_range(0, 2) == 0);
            we     = $urandom_range(0, 1) == 1;
            addr   = 2'($urandom_range(0, 3));
            wdata  = $urandom;
            if (addr == 2'd3) wdata[0] = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        req = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the Frost32Cpu `interrupt` input. It replaces the hand-driven interrupt pulses used at bench level.
- Collects NUM_SRC synchronous interrupt sources, latches rising edges into a pending register, applies mask, global enable and fixed priority.
- Emits a fixed-length interrupt pulse to the CPU, only while the CPU is not stalled on memory (`wait_for_mem` low).
- Software services the pending source through a small single-cycle register port.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31.
- PULSE_LEN, 3, cycles the `interrupt` output is held high per event; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  NUM_SRC  interrupt sources, synchronous to clk, rising-edge sensitive.
- cpu_wait_for_mem  in  1  CPU memory-stall indication (same signal fed to Frost32Cpu `wait_for_mem`).
- interrupt  out  1  to Frost32Cpu `interrupt`.
- reg_req  in  1  register access request, one-cycle strobe.
- reg_we  in  1  1 = write, 0 = read; qualified by reg_req.
- reg_addr  in  2  register select.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid when reg_ack = 1.
- reg_ack  out  1  access complete.

Behaviour:
- Reset (rst=1 at posedge): interrupt=0, reg_ack=0, reg_rdata=0, pending=0, mask=0, enable=0, edge-detect history=0, FSM=IDLE, pulse counter=0, cause latch=0.
- Edge detect: `prev <= irq_src` each cycle; `rise = irq_src & ~prev`. A source held high at reset release counts as a rise on the first post-reset cycle.
- Pending update: `pending <= (pending & ~clr) | rise`, where clr = W1C write mask. Set beats clear when both hit the same bit in the same cycle.
- Registers (bits above NUM_SRC read 0, writes ignored):
  - addr 0 PENDING: read; write-1-to-clear.
  - addr 1 MASK: read/write; 1 = source enabled.
  - addr 2 CAUSE: read-only. Bit31 = |(pending & mask); bits[4:0] = lowest index set in pending & mask, 0 if none.
  - addr 3 CTRL: bit0 = global enable, read/write; other bits read 0.
- Register timing: reg_req sampled at posedge N; reg_ack=1 and reg_rdata valid during cycle N+1 only. Write side effects are visible in registers from cycle N+1. Back-to-back requests are legal, one per cycle. reg_rdata=0 whenever reg_ack=0.
- Priority: lowest index wins. The cause index is latched at pulse start.
- FSM:
  - IDLE: if enable && |(pending&mask) && !cpu_wait_for_mem, latch cause, load counter = PULSE_LEN, go to PULSE. Otherwise stay.
  - PULSE: interrupt=1. Counter decrements each cycle. When counter reaches 1, go to IN_SERVICE on the next edge. interrupt is high for exactly PULSE_LEN cycles. cpu_wait_for_mem going high mid-pulse does not shorten or extend the pulse.
  - IN_SERVICE: interrupt=0. Return to IDLE when pending[cause]=0, or mask[cause]=0, or enable=0.
  - IDLE is held at least one cycle between pulses, so pulses are never merged.
- interrupt is a registered output, high only in PULSE. It asserts the cycle after the IDLE launch condition is sampled.
- Disabling enable during PULSE: the pulse completes, then the FSM goes IN_SERVICE → IDLE immediately.
- rst in any state: returns to the reset values on that edge; no residual pulse.
- New rises during PULSE or IN_SERVICE are latched in pending and serviced after return to IDLE.

Test Plan:
- Reset with irq_src=0, enable=1, mask=0xFF, no events → interrupt stays 0 for 50 cycles; CAUSE reads 0x00000000.
- mask=0xFF, CTRL=1; pulse irq_src[3] 0→1 → PENDING reads 0x08, CAUSE reads 0x80000003; interrupt high exactly 3 cycles starting 1 cycle after the edge registers; write PENDING=0x08 → FSM to IDLE; no further pulse.
- irq_src[5] and irq_src[2] rise same cycle → CAUSE=0x80000002, one pulse. After W1C 0x04, a second pulse follows with CAUSE=0x80000005.
- Hold cpu_wait_for_mem=1 for 10 cycles while pending[0] is set and enabled → interrupt stays 0; it rises on the cycle after wait drops.
- Same-cycle W1C of bit 1 and a new rise on irq_src[1] → PENDING reads 0x02 afterwards (set wins).
- Assert rst during the 2nd pulse cycle → interrupt=0 the next cycle; PENDING, MASK and CTRL read 0; irq_src still high produces no event until enable and mask are restored and a new rise occurs.
